// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Purpose: shared types and constants for the etherneco sync-timer master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jellyvl_etherneco_synctimer_pkg;

  localparam int CMD_HDR_LEN  = 9;  // flag byte + 8 time bytes
  localparam int OFFSET_BYTES = 4;  // bytes per offset / elapsed entry

  typedef logic [3:0][7:0] t_offset;  // 32-bit value, byte addressable
  typedef logic [7:0][7:0] t_time;    // 64-bit time, byte addressable

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RES,
    ST_CALC
  } t_state;

endpackage

// File: rtl/jellyvl_etherneco_synctimer_master_tx.sv
// Purpose: serialises one command packet of len bytes onto a valid/ready byte stream.
// Latency: first byte valid the cycle after start; one byte per accepted handshake.
// Backpressure: pos/first/last/data held while m_cmd_valid && !m_cmd_ready.
//
// Ports: start/len load a packet; byte_pos/byte_data fetch the byte for the
// current position from the parent; done pulses (comb) on the last handshake.
module jellyvl_etherneco_synctimer_master_tx (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] len,
  output logic [15:0] byte_pos,
  input  logic [7:0]  byte_data,
  output logic        done,
  output logic        m_cmd_first,
  output logic        m_cmd_last,
  output logic [15:0] m_cmd_pos,
  output logic [7:0]  m_cmd_data,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready
);

  logic [15:0] pos_q;
  logic [15:0] last_pos_q;
  logic        vld_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q      <= 1'b0;
      pos_q      <= 16'd0;
      last_pos_q <= 16'd0;
    end else if (start && !vld_q) begin
      vld_q      <= 1'b1;
      pos_q      <= 16'd0;
      last_pos_q <= len - 16'd1;
    end else if (vld_q && m_cmd_ready) begin
      if (pos_q == last_pos_q) begin
        vld_q <= 1'b0;
      end else begin
        pos_q <= pos_q + 16'd1;
      end
    end
  end

  // Data is looked up from pos_q, which only moves on a handshake, and the
  // parent's sources are frozen during SEND, so the byte is stable while stalled.
  assign byte_pos    = pos_q;
  assign m_cmd_pos   = pos_q;
  assign m_cmd_data  = byte_data;
  assign m_cmd_first = (pos_q == 16'd0);
  assign m_cmd_last  = (pos_q == last_pos_q);
  assign m_cmd_valid = vld_q;
  assign done        = vld_q && m_cmd_ready && m_cmd_last;

endmodule

// File: rtl/jellyvl_etherneco_synctimer_master_core.sv
// Purpose: sync-timer master; sends time+offset command, measures round trip, updates offset table.
// Latency: SEND starts 1 cycle after start; CALC takes node_count cycles after last response byte.
// Backpressure: command stream stalls on m_cmd_ready; response stream is never backpressured.
//
// Ports: start/start_renew/start_correct/node_count/current_time sampled in IDLE;
// m_cmd_* command byte stream out; s_res_*/res_rx_error response stream in;
// busy, monitor_round_trip, monitor_done status out.
// Option: define JELLYVL_SYNCTIMER_MASTER_LPF_EN to low-pass filter offset updates.
module jellyvl_etherneco_synctimer_master_core
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH = 64,
  parameter int MAX_NODES   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [TIMER_WIDTH-1:0] current_time,
  input  logic [7:0]             node_count,
  input  logic                   start,
  input  logic                   start_renew,
  input  logic                   start_correct,
  output logic                   busy,
  output logic                   m_cmd_first,
  output logic                   m_cmd_last,
  output logic [15:0]            m_cmd_pos,
  output logic [7:0]             m_cmd_data,
  output logic                   m_cmd_valid,
  input  logic                   m_cmd_ready,
  input  logic                   s_res_first,
  input  logic                   s_res_last,
  input  logic [15:0]            s_res_pos,
  input  logic [7:0]             s_res_data,
  input  logic                   s_res_valid,
  input  logic                   res_rx_error,
  output logic [31:0]            monitor_round_trip,
  output logic                   monitor_done
);

  localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  t_state                        state;
  logic                          renew_q;
  logic                          correct_q;
  t_time                         time_q;
  logic [7:0]                    node_cnt_q;
  logic [31:0]                   t_send;
  logic [31:0]                   t_ret;
  logic [7:0]                    calc_idx;
  t_offset [MAX_NODES-1:0]       offset_tbl;
  t_offset [MAX_NODES-1:0]       elapsed;

  // Out-of-range counts are clamped so table indices always stay in bounds.
  logic [7:0] cnt_in;
  always_comb begin
    cnt_in = node_count;
    if (node_count == 8'd0) begin
      cnt_in = 8'd1;
    end else if (node_count > 8'(MAX_NODES)) begin
      cnt_in = 8'(MAX_NODES);
    end
  end

  logic        tx_start;
  logic [15:0] tx_len;
  logic [15:0] tx_pos;
  logic [15:0] tx_rel;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic [IDX_W-1:0] tx_node;

  assign tx_start = (state == ST_IDLE) && start;
  assign tx_len   = 16'(CMD_HDR_LEN) + 16'(cnt_in) * 16'(OFFSET_BYTES);
  assign tx_rel   = tx_pos - 16'(CMD_HDR_LEN);
  assign tx_node  = IDX_W'(tx_rel >> 2);

  always_comb begin
    tx_byte = 8'h00;
    if (tx_pos == 16'd0) begin
      tx_byte = {6'b0, renew_q, correct_q};
    end else if (tx_pos < 16'(CMD_HDR_LEN)) begin
      tx_byte = time_q[3'(tx_pos[2:0] - 3'd1)];  // pos 1..8 -> time byte 0..7
    end else begin
      tx_byte = offset_tbl[tx_node][tx_rel[1:0]];
    end
  end

  jellyvl_etherneco_synctimer_master_tx u_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (tx_start),
    .len         (tx_len),
    .byte_pos    (tx_pos),
    .byte_data   (tx_byte),
    .done        (tx_done),
    .m_cmd_first (m_cmd_first),
    .m_cmd_last  (m_cmd_last),
    .m_cmd_pos   (m_cmd_pos),
    .m_cmd_data  (m_cmd_data),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_ready (m_cmd_ready)
  );

  // Response bytes in the offset area carry each node's elapsed time.
  logic [15:0]      res_rel;
  logic [IDX_W-1:0] res_node;
  logic             res_hit;
  assign res_rel  = s_res_pos - 16'(CMD_HDR_LEN);
  assign res_node = IDX_W'(res_rel >> 2);
  assign res_hit  = (s_res_pos >= 16'(CMD_HDR_LEN)) && ((res_rel >> 2) < 16'(node_cnt_q));

  logic [IDX_W-1:0] calc_ptr;
  logic [31:0]      round_trip;
  logic [31:0]      calc_new;
  logic [31:0]      offset_wr;
  assign calc_ptr   = IDX_W'(calc_idx);
  assign round_trip = t_ret - t_send;
  assign calc_new   = (round_trip - elapsed[calc_ptr]) >> 1;

`ifdef JELLYVL_SYNCTIMER_MASTER_LPF_EN
  // Step kept in its own signed signal so the shift stays arithmetic.
  logic [31:0]        lpf_diff;
  logic signed [31:0] lpf_step;
  assign lpf_diff  = calc_new - offset_tbl[calc_ptr];
  assign lpf_step  = $signed(lpf_diff) >>> 2;
  assign offset_wr = offset_tbl[calc_ptr] + lpf_step;
`else
  assign offset_wr = calc_new;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      busy               <= 1'b0;
      monitor_done       <= 1'b0;
      monitor_round_trip <= 32'd0;
      renew_q            <= 1'b0;
      correct_q          <= 1'b0;
      time_q             <= '0;
      node_cnt_q         <= 8'd1;
      t_send             <= 32'd0;
      t_ret              <= 32'd0;
      calc_idx           <= 8'd0;
      offset_tbl         <= '0;
      elapsed            <= '0;
    end else begin
      monitor_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            time_q     <= t_time'(current_time);
            renew_q    <= start_renew;
            correct_q  <= start_correct;
            node_cnt_q <= cnt_in;
            busy       <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_cmd_valid && m_cmd_ready && m_cmd_first) begin
            t_send <= current_time[31:0];
          end
          if (tx_done) begin
            state <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (res_rx_error) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (s_res_valid) begin
            if (s_res_first) begin
              t_ret <= current_time[31:0];
            end
            if (res_hit) begin
              elapsed[res_node][res_rel[1:0]] <= s_res_data;
            end
            if (s_res_last) begin
              calc_idx <= 8'd0;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          offset_tbl[calc_ptr] <= offset_wr;
          calc_idx             <= calc_idx + 8'd1;
          if (calc_idx == node_cnt_q - 8'd1) begin
            monitor_round_trip <= round_trip;
            monitor_done       <= 1'b1;
            busy               <= 1'b0;
            state              <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jellyvl_etherneco_synctimer_master_core.md
JELLYVL_ETHERNECO_SYNCTIMER_MASTER_CORE -- requirements
Module: jellyvl_etherneco_synctimer_master_core

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64: width of current_time.
REQ-002 SHALL have parameter MAX_NODES, default 8: number of offset table entries.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on posedge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port current_time, input, TIMER_WIDTH: master reference time.
REQ-006 SHALL have port node_count, input, 8: active slaves, legal range 1..MAX_NODES.
REQ-007 SHALL have ports start / start_renew / start_correct, input, 1 each: start request and the cmd flag bits.
REQ-008 SHALL have port busy, output, 1: high from accepted start until return to IDLE.
REQ-009 SHALL have ports m_cmd_first/last, output, 1; m_cmd_pos, output, 16; m_cmd_data, output, 8; m_cmd_valid, output, 1; m_cmd_ready, input, 1: command byte stream.
REQ-010 SHALL have ports s_res_first/last/valid, input, 1; s_res_pos, input, 16; s_res_data, input, 8; res_rx_error, input, 1: returned response stream.
REQ-011 SHALL have ports monitor_round_trip, output, 32; monitor_done, output, 1: last measured round trip, one-cycle completion pulse.

Function
REQ-012 SHALL run FSM IDLE -> SEND -> WAIT_RES -> CALC -> IDLE.
REQ-013 In IDLE, start=1 SHALL latch current_time, start_renew, start_correct, node_count, and enter SEND next cycle; start ignored outside IDLE.
REQ-014 SEND SHALL emit 9+4*node_count bytes, pos 0..N-1, first at pos 0, last at pos N-1.
REQ-015 Byte layout SHALL be: pos0 = {6'b0, renew, correct}; pos1..8 = latched time, little-endian; pos 9+4*(n-1)..+3 = offset[n-1], 32-bit LE, n=1..node_count.
REQ-016 A byte SHALL transfer only when m_cmd_valid && m_cmd_ready; data/pos/first/last SHALL hold while valid && !ready.
REQ-017 On pos-0 transfer SHALL latch current_time[31:0] as t_send.
REQ-018 After last transfer SHALL enter WAIT_RES with m_cmd_valid=0.
REQ-019 In WAIT_RES, s_res_valid && s_res_first SHALL latch t_ret = current_time[31:0]; bytes at pos 9+4*(n-1)+i (i=0..3, n<=node_count) SHALL write byte i of elapsed[n-1].
REQ-020 s_res_valid && s_res_last SHALL enter CALC; res_rx_error SHALL abort to IDLE, table unchanged, no monitor_done.
REQ-021 CALC SHALL take one cycle per node: round = t_ret - t_send (mod 2^32); new = (round - elapsed[n]) >> 1, logical shift, 32-bit wrap.
REQ-022 After last node SHALL update monitor_round_trip, pulse monitor_done one cycle, return to IDLE.
REQ-023 Offsets for n >= node_count SHALL be unchanged.

Reset
REQ-024 reset_n=0 at any clock edge, including mid-SEND, SHALL force IDLE, busy=0, m_cmd_valid=0, monitor_done=0, monitor_round_trip=0, offset table=0; m_cmd_data/pos/first/last SHALL be don't-care while invalid.

Configuration
REQ-025 With JELLYVL_SYNCTIMER_MASTER_LPF_EN defined, CALC SHALL write offset += (new - offset) >>> 2 (signed); without it, offset = new.

Structure
REQ-026 Package jellyvl_etherneco_synctimer_pkg SHALL hold CMD_HDR_LEN=9, OFFSET_BYTES=4, t_offset (4x8 bit), t_time (8x8 bit), FSM state enum.
REQ-027 Byte serialiser with ready/valid hold SHALL be sub-module jellyvl_etherneco_synctimer_master_tx.

Verification
REQ-028 node_count=2, current_time=0x0123456789ABCDEF, renew=1, correct=1, ready=1 -> 17 bytes, pos0=0x03, pos1=0xEF..pos8=0x01, pos9..16 = zero offsets.
REQ-029 ready toggled 1/0 each cycle -> same 17 bytes, no duplicate/loss, data stable while stalled.
REQ-030 t_send=1000, t_ret=1400, elapsed[0]=300, elapsed[1]=100 -> offsets 50, 150 (LPF off); monitor_round_trip=400; one monitor_done.
REQ-031 res_rx_error in WAIT_RES -> IDLE, offsets unchanged, no monitor_done.
REQ-032 reset_n=0 at byte 5 of SEND -> m_cmd_valid=0 next cycle, busy=0, new start sends full packet from pos0.
REQ-033 t_send=0xFFFFFF00, t_ret=0x00000100, elapsed=0 -> round=0x200, offset=0x100.
